// File: rtl/muldiv_pkg.sv
// Shared types, decode constants and op-classification helpers for the
// RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } md_state_t;

  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Upper half of the Funct3 space is the divide family
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // REM/REMU return the remainder instead of the quotient
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one bit per step of unsigned shift-add multiply or
// restoring divide on operand magnitudes. {acc_hi, acc_lo} holds the
// product (multiply) or {remainder, quotient} (divide) after DATA_WIDTH steps.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  div_mode,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] acc_hi,
  output logic [DATA_WIDTH-1:0] acc_lo
);

  logic [DATA_WIDTH-1:0] divisor;
  logic                  mode_div;
  logic [DATA_WIDTH:0]   add_sum;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;

  // Add/subtract candidates for the current step
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : '0);
    shifted = {acc_hi, acc_lo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = (shifted >= {1'b0, divisor});
  end

  // Operand load on start, then one iteration per step
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      divisor  <= '0;
      mode_div <= 1'b0;
    end else if (start) begin
      acc_hi   <= '0;
      acc_lo   <= op_a;
      divisor  <= op_b;
      mode_div <= div_mode;
    end else if (step) begin
      if (mode_div) begin
        acc_hi <= fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        acc_lo <= {acc_lo[DATA_WIDTH-2:0], fits};
      end else begin
        {acc_hi, acc_lo} <= {add_sum, acc_lo[DATA_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage controller for RV32M ops: decodes M-extension instructions,
// latches operand magnitudes and sign flags, sequences the iterative core,
// applies sign correction and stalls the pipeline until Result is ready.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  flush,
  input  logic [1:0]            ALUOp,
  input  logic [6:0]            Funct7,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Stall,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  md_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            op;
  logic                  neg_lo;
  logic                  neg_hi;
  logic                  special_q;
  logic [DATA_WIDTH-1:0] special_val_q;

  logic                  is_md;
  logic                  accept;
  logic                  sa;
  logic                  sb;
  logic [DATA_WIDTH-1:0] mag_a;
  logic [DATA_WIDTH-1:0] mag_b;
  logic                  div_by_zero;
  logic                  div_ovf;
  logic                  special;
  logic [DATA_WIDTH-1:0] special_val;

  logic [DATA_WIDTH-1:0]   core_hi;
  logic [DATA_WIDTH-1:0]   core_lo;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quo_fix;
  logic [DATA_WIDTH-1:0]   rem_fix;
  logic [DATA_WIDTH-1:0]   fix_val;

  // Decode, operand magnitudes and special-case detection for the EX op
  always_comb begin
    is_md       = ex_valid && (ALUOp == ALUOP_RTYPE) && (Funct7 == MULDIV_FUNCT7);
    accept      = (state == IDLE) && is_md && !flush;
    sa          = is_signed_a(Funct3) & SrcA[DATA_WIDTH-1];
    sb          = is_signed_b(Funct3) & SrcB[DATA_WIDTH-1];
    mag_a       = sa ? ('0 - SrcA) : SrcA;
    mag_b       = sb ? ('0 - SrcB) : SrcB;
    div_by_zero = is_div(Funct3) && (SrcB == '0);
    div_ovf     = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                  (SrcA == MIN_NEG) && (SrcB == '1);
    special     = div_by_zero || div_ovf;
    special_val = '0;
    if (div_by_zero) begin
      special_val = is_rem(Funct3) ? SrcA : '1;
    end else if (div_ovf) begin
      special_val = is_rem(Funct3) ? '0 : MIN_NEG;
    end
  end

  // Sign correction and word selection applied in FIX
  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = neg_lo ? ('0 - prod) : prod;
    quo_fix  = neg_lo ? ('0 - core_lo) : core_lo;
    rem_fix  = neg_hi ? ('0 - core_hi) : core_hi;
    case (op)
      F3_MUL:                        fix_val = prod_fix[DATA_WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_val = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      F3_DIV, F3_DIVU:               fix_val = quo_fix;
      default:                       fix_val = rem_fix;
    endcase
  end

  // Pipeline handshake decoded from state and the live inputs
  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE) && !flush;
    case (state)
      IDLE:      Stall = is_md;
      CALC, FIX: Stall = 1'b1;
      default:   Stall = 1'b0;
    endcase
  end

  muldiv_iter_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .div_mode (is_div(Funct3)),
    .step     (state == CALC),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .acc_hi   (core_hi),
    .acc_lo   (core_lo)
  );

  // Control FSM; special cases pass through FIX with a precomputed value so
  // every Result load happens on the FIX edge and a flush there discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op            <= '0;
      neg_lo        <= 1'b0;
      neg_hi        <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      Result        <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            op            <= Funct3;
            neg_lo        <= sa ^ sb;
            neg_hi        <= sa;
            special_q     <= special;
            special_val_q <= special_val;
            if (special) begin
              state <= FIX;
            end else begin
              cnt   <= CNT_W'(DATA_WIDTH - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          Result <= special_q ? special_val_q : fix_val;
          state  <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver issues M-ops and pushes
// expected result and Done cycle; a monitor pops on every Done pulse.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_valid;
  logic         flush;
  logic [1:0]   ALUOp;
  logic [6:0]   Funct7;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         Stall;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sbq[$];

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_valid (ex_valid),
    .flush    (flush),
    .ALUOp    (ALUOp),
    .Funct7   (Funct7),
    .Funct3   (Funct3),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Stall    (Stall),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // RV32M semantics written directly from the ISA rules
  function automatic logic [W-1:0] ref_result(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      x, y;
    logic [63:0] p;
    case (f3)
      3'd0: return a * b;
      3'd1: begin x = $signed(a); y = $signed(b); p = x * y; return p[63:32]; end
      3'd2: begin x = $signed(a); y = {32'd0, b}; p = x * y; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        x = $signed(a); y = $signed(b); p = x / y; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        x = $signed(a); y = $signed(b); p = x % y; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Cycles from the accepting cycle to the Done pulse
  function automatic int ref_latency(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    if (f3 >= 3'd4 && b == 0) return 2;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 34;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    int unsigned sel;
    sel = $urandom_range(0, 6);
    case (sel)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(1, 20));
      4: return 32'(0 - $urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic go_idle();
    ex_valid = 1'b0;
    ALUOp    = 2'b00;
    Funct7   = 7'd0;
    Funct3   = 3'd0;
  endtask

  // Called just after a rising edge; returns just after the edge that ends
  // the Done cycle so a following call is a back-to-back issue.
  task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expv, input string nm);
    exp_t e;
    bit   stall_ok;
    bit   seen;
    ex_valid = 1'b1;
    ALUOp    = ALUOP_RTYPE;
    Funct7   = MULDIV_FUNCT7;
    Funct3   = f3;
    SrcA     = a;
    SrcB     = b;
    e.res    = expv;
    e.cyc    = cyc + ref_latency(f3, a, b);
    e.name   = nm;
    sbq.push_back(e);
    stall_ok = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (Done) begin
        seen = 1'b1;
        if (Stall) stall_ok = 1'b0;
      end else if (!Stall) begin
        stall_ok = 1'b0;
      end
    end
    check(seen, {nm, "_done_seen"}, 64'(seen), 64'd1);
    check(stall_ok, {nm, "_stall"}, 64'(stall_ok), 64'd1);
    @(posedge clk); #1;
    go_idle();
  endtask

  // Monitor: every Done pulse must match the oldest expected entry
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (Done) begin
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_done", 64'(Result), 64'd0);
        end else begin
          e = sbq.pop_front();
          check(Result == e.res, e.name, 64'(Result), 64'(e.res));
          check(cyc == e.cyc, {e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int           t;
    bit           quiet;
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset = 1'b1;
    flush = 1'b0;
    SrcA  = '0;
    SrcB  = '0;
    go_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(Result == 0, "reset_result", 64'(Result), 64'd0);
    check(!Done,  "reset_done",  64'(Done),  64'd0);
    check(!Busy,  "reset_busy",  64'(Busy),  64'd0);
    check(!Stall, "reset_stall", 64'(Stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases; consecutive calls exercise back-to-back issue
    run_op(F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3");
    run_op(F3_MUL,    32'd3,          32'd5,        32'd15,       "mul_b2b");
    run_op(F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    run_op(F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, "mulh_min");
    run_op(F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, "div_m7_2");
    run_op(F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, "rem_m7_2");
    run_op(F3_DIVU,   32'h1234,       32'd0,        32'hFFFFFFFF, "divu_by0");
    run_op(F3_REMU,   32'h1234,       32'd0,        32'h1234,     "remu_by0");
    run_op(F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run_op(F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        "rem_ovf");
    run_op(F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    run_op(F3_MUL,    32'd5,          32'd6,        32'd30,       "mul_5_6");

    // Flush a DIVU at T+10: no Done, Result kept, idle at T+11
    ex_valid = 1'b1; ALUOp = ALUOP_RTYPE; Funct7 = MULDIV_FUNCT7; Funct3 = F3_DIVU;
    SrcA = 32'd1000; SrcB = 32'd7;
    t = cyc;
    repeat (10) @(posedge clk);
    #1;
    check(cyc == t + 10, "flush_timing", 64'(cyc), 64'(t + 10));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    go_idle();
    @(negedge clk);
    check(!Busy,  "flush_busy",  64'(Busy),  64'd0);
    check(!Stall, "flush_stall", 64'(Stall), 64'd0);
    check(Result == 32'd30, "flush_result_kept", 64'(Result), 64'd30);
    @(posedge clk); #1;
    run_op(F3_MUL, 32'd123, 32'hFFFFFFFE, 32'hFFFFFF0A, "mul_after_flush");

    // Non-M instructions never stall or start the sequencer
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0: begin ex_valid = 1'b1; ALUOp = 2'b10; Funct7 = 7'd0; end
        1: begin ex_valid = 1'b1; ALUOp = 2'b00; Funct7 = MULDIV_FUNCT7; end
        default: begin ex_valid = 1'b0; ALUOp = 2'b10; Funct7 = MULDIV_FUNCT7; end
      endcase
      Funct3 = 3'($urandom_range(0, 7));
      SrcA = $urandom();
      SrcB = $urandom();
      @(negedge clk);
      if (Stall || Busy || Done) quiet = 1'b0;
      @(posedge clk); #1;
    end
    check(quiet, "non_m_quiet", 64'(quiet), 64'd1);
    go_idle();

    // Reset mid-multiply: everything back to zero on the next cycle
    ex_valid = 1'b1; ALUOp = ALUOP_RTYPE; Funct7 = MULDIV_FUNCT7; Funct3 = F3_MUL;
    SrcA = 32'd9; SrcB = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    go_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check(Result == 0, "midreset_result", 64'(Result), 64'd0);
    check(!Busy,  "midreset_busy",  64'(Busy),  64'd0);
    check(!Stall, "midreset_stall", 64'(Stall), 64'd0);
    check(!Done,  "midreset_done",  64'(Done),  64'd0);
    @(posedge clk); #1;

    // Randomized ops against the ISA-level model
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(f3, a, b, ref_result(f3, a, b), $sformatf("rnd%0d_f%0d", n, f3));
    end

    repeat (5) @(posedge clk);
    check(sbq.size() == 0, "scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
